// File: rtl/change_dispense_ctrl_pkg.sv
// vend_pkg: definitions shared by the vending machine controllers.
//   - coin codes as reported by the coin acceptor (coin_in)
//   - vending FSM state codes
//   - change_dispense_ctrl state enum
//   - coin values expressed in nickels
package vend_pkg;

  localparam logic [2:0] NICKEL      = 3'b001;
  localparam logic [2:0] DIME        = 3'b010;
  localparam logic [2:0] NICKEL_DIME = 3'b011;
  localparam logic [2:0] DIME_DIME   = 3'b100;
  localparam logic [2:0] QUARTER     = 3'b101;

  typedef enum logic [2:0] {
    VEND_IDLE,
    VEND_COLLECT,
    VEND_SELECT,
    VEND_DISPENSE,
    VEND_CHANGE
  } vend_state_t;

  typedef enum logic [2:0] {
    CD_IDLE,
    CD_SELECT,
    CD_EJECT,
    CD_WAIT_ACK,
    CD_DONE,
    CD_FAULT
  } cd_state_t;

  localparam logic [2:0] NICKEL_VALUE = 3'd1;
  localparam logic [2:0] DIME_VALUE   = 3'd2;

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// change_dispense_ctrl_if: request, refill, hopper and status signals of the
// change dispenser.
//   master: vending FSM / coin acceptor / hoppers (drive requests, coins, acks)
//   slave : change_dispense_ctrl
interface change_dispense_ctrl_if;
  import vend_pkg::*;

  logic       req_valid;
  logic [2:0] req_change;
  logic       req_ready;
  logic       coin_in_valid;
  logic [2:0] coin_in;
  logic       eject_nickel;
  logic       eject_dime;
  logic       eject_ack;
  logic       busy;
  logic       done;
  logic       fault;
  logic [2:0] short_amt;
  logic       exact_change;
  logic       nickel_full;
  logic       dime_full;

  modport master (
    output req_valid, req_change, coin_in_valid, coin_in, eject_ack,
    input  req_ready, eject_nickel, eject_dime, busy, done, fault, short_amt,
           exact_change, nickel_full, dime_full
  );

  modport slave (
    input  req_valid, req_change, coin_in_valid, coin_in, eject_ack,
    output req_ready, eject_nickel, eject_dime, busy, done, fault, short_amt,
           exact_change, nickel_full, dime_full
  );

endinterface

// File: rtl/change_dispense_ctrl_coin_tube_counter.sv
// coin_tube_counter: saturating up/down coin count for one payout tube.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   inc          : coin added to the tube (ignored when full)
//   dec          : coin dropped from the tube (ignored when empty)
//   count        : coins currently held
//   full, empty  : count == DEPTH, count == 0
module coin_tube_counter #(
  parameter int DEPTH = 31,
  parameter int W     = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam logic [W-1:0] MAX = W'(DEPTH);

  // A coin arriving in the same cycle one leaves nets to zero, even at the
  // full limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && (count != MAX)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign full  = (count == MAX);
  assign empty = (count == '0);

endmodule

// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: pays out change (in nickels) greedily, dime first,
// using a one-cycle eject pulse / acknowledge handshake per coin.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : request (req_*), refill (coin_in*), hopper (eject_*),
//                  status (busy, done, fault, short_amt, exact_change, *_full)
// Build option CHANGE_INVENTORY_EN: track tube contents, allow shortfall
// faults and drive exact_change / *_full. Without it tubes are bottomless.
//
// state       | meaning
// ------------+---------------------------------------------
// CD_IDLE     | req_ready high, waiting for a request
// CD_SELECT   | pick next coin, or finish / shortfall fault
// CD_EJECT    | eject pulse on the chosen hopper
// CD_WAIT_ACK | waiting for eject_ack, bounded by ACK_TIMEOUT
// CD_DONE     | done pulse
// CD_FAULT    | terminal until reset
module change_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int TUBE_DEPTH  = 31,
  parameter int CNT_W       = 5,
  parameter int ACK_TIMEOUT = 15
) (
  input logic                   clock,
  input logic                   reset,
  change_dispense_ctrl_if.slave bus
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  cd_state_t        state, state_nx;
  logic [2:0]       remaining, remaining_nx;
  logic             sel_dime, sel_dime_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic             ack_take;
  logic             has_dime, has_nickel;

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    sel_dime_nx  = sel_dime;
    timer_nx     = timer;
    ack_take     = 1'b0;
    case (state)
      CD_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          remaining_nx = bus.req_change;
          state_nx     = CD_SELECT;
        end
      end
      CD_SELECT: begin
        if ((remaining >= DIME_VALUE) && has_dime) begin
          sel_dime_nx = 1'b1;
          state_nx    = CD_EJECT;
        end else if ((remaining >= NICKEL_VALUE) && has_nickel) begin
          sel_dime_nx = 1'b0;
          state_nx    = CD_EJECT;
        end else if (remaining == '0) begin
          state_nx = CD_DONE;
        end else begin
          state_nx = CD_FAULT;
        end
      end
      CD_EJECT: begin
        // The final WAIT_ACK cycle is the one where the timer reads zero.
        timer_nx = TMR_W'(ACK_TIMEOUT - 1);
        state_nx = CD_WAIT_ACK;
      end
      CD_WAIT_ACK: begin
        if (bus.eject_ack) begin
          ack_take     = 1'b1;
          remaining_nx = remaining - (sel_dime ? DIME_VALUE : NICKEL_VALUE);
          state_nx     = CD_SELECT;
        end else if (timer == '0) begin
          state_nx = CD_FAULT;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      CD_DONE:  state_nx = CD_IDLE;
      CD_FAULT: state_nx = CD_FAULT;
      default:  state_nx = CD_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so each one lines up
  // with the state it describes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= CD_IDLE;
      remaining        <= '0;
      sel_dime         <= 1'b0;
      timer            <= '0;
      bus.req_ready    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.eject_dime   <= 1'b0;
      bus.eject_nickel <= 1'b0;
      bus.done         <= 1'b0;
      bus.fault        <= 1'b0;
      bus.short_amt    <= '0;
    end else begin
      state            <= state_nx;
      remaining        <= remaining_nx;
      sel_dime         <= sel_dime_nx;
      timer            <= timer_nx;
      bus.req_ready    <= (state_nx == CD_IDLE);
      bus.busy         <= (state_nx != CD_IDLE);
      bus.eject_dime   <= (state_nx == CD_EJECT) && sel_dime_nx;
      bus.eject_nickel <= (state_nx == CD_EJECT) && !sel_dime_nx;
      bus.done         <= (state_nx == CD_DONE);
      if (state_nx == CD_FAULT) begin
        bus.fault     <= 1'b1;
        bus.short_amt <= remaining_nx;
      end
    end
  end

`ifdef CHANGE_INVENTORY_EN
  logic [CNT_W-1:0] nickel_count;
  logic [CNT_W-1:0] dime_count_unused;
  logic             nickel_full_c, nickel_empty;
  logic             dime_full_c, dime_empty;

  coin_tube_counter #(.DEPTH(TUBE_DEPTH), .W(CNT_W)) u_nickel_tube (
    .clock (clock),
    .reset (reset),
    .inc   (bus.coin_in_valid && (bus.coin_in == NICKEL)),
    .dec   (ack_take && !sel_dime),
    .count (nickel_count),
    .full  (nickel_full_c),
    .empty (nickel_empty)
  );

  coin_tube_counter #(.DEPTH(TUBE_DEPTH), .W(CNT_W)) u_dime_tube (
    .clock (clock),
    .reset (reset),
    .inc   (bus.coin_in_valid && (bus.coin_in == DIME)),
    .dec   (ack_take && sel_dime),
    .count (dime_count_unused),
    .full  (dime_full_c),
    .empty (dime_empty)
  );

  assign has_dime   = !dime_empty;
  assign has_nickel = !nickel_empty;

  // Flags are flopped so they read 0 during reset even though empty tubes
  // would otherwise mean exact change only.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.exact_change <= 1'b0;
      bus.nickel_full  <= 1'b0;
      bus.dime_full    <= 1'b0;
    end else begin
      bus.exact_change <= (nickel_count < CNT_W'(2));
      bus.nickel_full  <= nickel_full_c;
      bus.dime_full    <= dime_full_c;
    end
  end
`else
  logic unused_inventory;

  assign has_dime         = 1'b1;
  assign has_nickel       = 1'b1;
  assign bus.exact_change = 1'b0;
  assign bus.nickel_full  = 1'b0;
  assign bus.dime_full    = 1'b0;
  assign unused_inventory = &{1'b0, bus.coin_in_valid, bus.coin_in, ack_take,
                              CNT_W'(TUBE_DEPTH)};
`endif

endmodule
